// File: rtl/uart_pkg.sv
// Shared UART types and helpers. The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with exact occupancy count; a push into a full FIFO succeeds when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/uart_fifo.sv
// UART with TX and RX FIFOs, sticky line errors and first-word-fall-through RX.
// Optional parity bit generation/checking is enabled by defining UART_PARITY_EN.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  input  logic                        serial_in,
  output logic                        serial_out,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        framing_error,
  output logic                        overrun_error,
  output logic                        parity_error,
  input  logic                        err_clear
);

  localparam int CPB   = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CPB / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;

  assign data_in_ready  = !tx_full && !reset;
  assign tx_push        = data_in_valid && data_in_ready;
  assign data_out_valid = !rx_empty && !reset;
  assign rx_pop         = data_out_valid && data_out_ready;
  assign data_out       = data_out_valid ? rx_head : '0;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .push_data(data_in), .pop(tx_pop),
    .pop_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift_q), .pop(rx_pop),
    .pop_data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_q;
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [BIT_W-1:0]     tx_idx_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_line_q;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_bit_end = (tx_cnt_q == CNT_LAST);
  // Popping at the end of STOP lets back-to-back characters leave without an idle gap.
  assign tx_pop     = !tx_empty && ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_bit_end));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      unique case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_state_q <= TX_START;
            tx_line_q  <= 1'b0;
          end
        end
        TX_START: if (tx_bit_end) begin
          tx_state_q <= TX_DATA;
          tx_idx_q   <= '0;
          tx_line_q  <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_idx_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_q <= TX_PARITY;
            tx_line_q  <= tx_par_q;
`else
            tx_state_q <= TX_STOP;
            tx_line_q  <= 1'b1;
`endif
          end else begin
            tx_idx_q   <= tx_idx_q + 1'b1;
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (tx_bit_end) begin
          tx_state_q <= TX_STOP;
          tx_line_q  <= 1'b1;
        end
`endif
        TX_STOP: if (tx_bit_end) begin
          if (tx_pop) begin
            tx_state_q <= TX_START;
            tx_line_q  <= 1'b0;
          end else begin
            tx_state_q <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
    if (tx_pop) begin
      tx_shift_q <= tx_head;
`ifdef UART_PARITY_EN
      tx_par_q   <= (^tx_head) ^ PAR_ODD;
`endif
    end
  end

  assign serial_out = tx_line_q;

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync_q, rx_sync_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 rx_bit, rx_mid, rx_stop_smp, rx_frame_err, rx_par_err;
  rx_state_t            rx_state_q;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [BIT_W-1:0]     rx_idx_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 framing_q, framing_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_overrun;

  assign rx_bit = rx_sync_q[1];
  // START waits half a bit, so every later full-bit wait lands on a bit centre.
  assign rx_mid = (rx_state_q == RX_START) ? (rx_cnt_q == CNT_MID) : (rx_cnt_q == CNT_LAST);
  assign rx_stop_smp  = (rx_state_q == RX_STOP) && rx_mid;
  assign rx_frame_err = rx_stop_smp && !rx_bit;

`ifdef UART_PARITY_EN
  logic rx_par_bad_q;
  logic parity_q, parity_d;
  assign rx_par_err = rx_stop_smp && rx_bit && rx_par_bad_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PAR_ODD;
  assign rx_par_err        = 1'b0;
`endif

  assign rx_push    = rx_stop_smp && rx_bit && !rx_par_err;
  assign rx_overrun = rx_push && rx_full && !rx_pop;

  always_comb begin
    rx_sync_d = {rx_sync_q[0], serial_in};
    rx_prev_d = rx_bit;
    framing_d = err_clear ? 1'b0 : framing_q;
    if (rx_frame_err) framing_d = 1'b1;
    overrun_d = err_clear ? 1'b0 : overrun_q;
    if (rx_overrun) overrun_d = 1'b1;
`ifdef UART_PARITY_EN
    parity_d = err_clear ? 1'b0 : parity_q;
    if (rx_par_err) parity_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
    end else begin
      rx_cnt_q <= rx_mid ? '0 : rx_cnt_q + 1'b1;
      unique case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_bit) rx_state_q <= RX_START;
        end
        RX_START: if (rx_mid) begin
          rx_state_q <= rx_bit ? RX_IDLE : RX_DATA;
          rx_idx_q   <= '0;
        end
        RX_DATA: if (rx_mid) begin
          rx_shift_q <= {rx_bit, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_q <= RX_PARITY;
`else
            rx_state_q <= RX_STOP;
`endif
          end else begin
            rx_idx_q <= rx_idx_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (rx_mid) begin
          rx_par_bad_q <= rx_bit != ((^rx_shift_q) ^ PAR_ODD);
          rx_state_q   <= RX_STOP;
        end
`endif
        RX_STOP: if (rx_mid) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign framing_error = framing_q;
  assign overrun_error = overrun_q;
`ifdef UART_PARITY_EN
  assign parity_error  = parity_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo at 10 clocks per bit with 4-entry FIFOs.
module tb_uart_fifo;

  localparam int CPB = 10;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          reset, data_in_valid, data_in_ready, data_out_valid, data_out_ready;
  logic          serial_in, serial_out, framing_error, overrun_error, parity_error, err_clear;
  logic [7:0]    data_in, data_out;
  logic [CW-1:0] tx_count, rx_count;
  logic          loop_en, drv_line;
  logic [7:0]    exp_a5;
  int            n_checks = 0;
  int            n_fail   = 0;
`ifdef UART_PARITY_EN
  logic          par_flip = 1'b0;
`endif

  assign serial_in = loop_en ? serial_out : drv_line;

  always #5 clk = ~clk;

  uart_fifo #(
    .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .serial_in(serial_in), .serial_out(serial_out),
    .tx_count(tx_count), .rx_count(rx_count),
    .framing_error(framing_error), .overrun_error(overrun_error), .parity_error(parity_error),
    .err_clear(err_clear)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    drv_line = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_v);
    drv_line = 1'b1;
    tick(3);
  endtask

  task automatic wait_rx(input int n, input int limit, input string tag);
    int k = 0;
    while (rx_count != CW'(n) && k < limit) begin
      tick(1);
      k++;
    end
    check(tag, 32'(rx_count), 32'(n));
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string tag);
    check({tag, "_valid"}, 32'(data_out_valid), 32'd1);
    check(tag, 32'(data_out), 32'(exp));
    data_out_ready = 1'b1;
    tick(1);
    data_out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    err_clear = 1'b0; loop_en = 1'b0; drv_line = 1'b1; exp_a5 = 8'hA5;
    tick(3);
    check("rst_serial_out", 32'(serial_out), 32'd1);
    check("rst_in_ready", 32'(data_in_ready), 32'd0);
    check("rst_out_valid", 32'(data_out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_errors", 32'({framing_error, overrun_error, parity_error}), 32'd0);
    reset = 1'b0;
    tick(1);
    check("ready_after_rst", 32'(data_in_ready), 32'd1);

    // Single TX frame: start bit one cycle after the pop, then A5 LSB first.
    data_in = 8'hA5; data_in_valid = 1'b1;
    tick(1);
    data_in_valid = 1'b0;
    check("tx_count_push", 32'(tx_count), 32'd1);
    check("tx_line_pre_start", 32'(serial_out), 32'd1);
    tick(1);
    check("tx_start_bit", 32'(serial_out), 32'd0);
    check("tx_count_pop", 32'(tx_count), 32'd0);
    tick(CPB - 1);
    check("tx_start_last", 32'(serial_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(i == 0 ? 1 : CPB);
      check($sformatf("tx_bit%0d", i), 32'(serial_out), 32'(exp_a5[i]));
    end
`ifdef UART_PARITY_EN
    tick(CPB);
    check("tx_parity", 32'(serial_out), 32'd0);
`endif
    tick(CPB);
    check("tx_stop", 32'(serial_out), 32'd1);
    tick(CPB + 5);
    check("tx_idle", 32'(serial_out), 32'd1);

    // Reset in the middle of a start bit returns the line high on the next edge.
    data_in = 8'h0F; data_in_valid = 1'b1;
    tick(1);
    data_in_valid = 1'b0;
    tick(3);
    check("tx2_start", 32'(serial_out), 32'd0);
    reset = 1'b1;
    tick(1);
    check("rst_mid_tx", 32'(serial_out), 32'd1);
    reset = 1'b0;
    tick(2 * CPB);
    check("tx_aborted_line", 32'(serial_out), 32'd1);
    check("tx_aborted_count", 32'(tx_count), 32'd0);

    // Loopback of three back-to-back characters.
    loop_en = 1'b1;
    data_in_valid = 1'b1;
    data_in = 8'h00; tick(1);
    data_in = 8'hFF; tick(1);
    data_in = 8'h3C; tick(1);
    data_in_valid = 1'b0;
    wait_rx(3, 600, "lb_rx_count");
    pop_expect(8'h00, "lb_0");
    pop_expect(8'hFF, "lb_1");
    pop_expect(8'h3C, "lb_2");
    check("lb_empty", 32'(rx_count), 32'd0);
    check("lb_errors", 32'({framing_error, overrun_error, parity_error}), 32'd0);
    tick(2 * CPB);
    loop_en = 1'b0;

    // Five frames into a 4-deep RX FIFO with no pops.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    check("ovr_rx_count", 32'(rx_count), 32'd4);
    check("ovr_flag", 32'(overrun_error), 32'd1);
    check("ovr_no_framing", 32'(framing_error), 32'd0);
    pop_expect(8'h11, "ovr_0");
    pop_expect(8'h22, "ovr_1");
    pop_expect(8'h33, "ovr_2");
    pop_expect(8'h44, "ovr_3");
    check("ovr_5th_absent", 32'(data_out_valid), 32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ovr_cleared", 32'(overrun_error), 32'd0);

    // Three-cycle low glitch is a false start; a real frame still follows.
    drv_line = 1'b0;
    tick(3);
    drv_line = 1'b1;
    tick(2 * CPB);
    check("glitch_no_push", 32'(rx_count), 32'd0);
    check("glitch_no_err", 32'(framing_error), 32'd0);
    send_frame(8'h5A, 1'b1);
    check("glitch_recover_count", 32'(rx_count), 32'd1);
    pop_expect(8'h5A, "glitch_recover");

    // Stop bit 0: framing error, character discarded, cleared by err_clear.
    send_frame(8'h77, 1'b0);
    check("frm_flag", 32'(framing_error), 32'd1);
    check("frm_rx_count", 32'(rx_count), 32'd0);
    tick(5);
    check("frm_sticky", 32'(framing_error), 32'd1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("frm_cleared", 32'(framing_error), 32'd0);

`ifdef UART_PARITY_EN
    // 0x01 with an even-parity bit of 0 instead of 1.
    par_flip = 1'b1;
    send_frame(8'h01, 1'b1);
    par_flip = 1'b0;
    check("par_flag", 32'(parity_error), 32'd1);
    check("par_no_push", 32'(rx_count), 32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("par_cleared", 32'(parity_error), 32'd0);
`else
    check("par_tied_low", 32'(parity_error), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
